// File: rtl/core_types_pkg.sv
// core_types_pkg: shared request/response types for the core's data-memory interface.
package core_types_pkg;
    localparam int MEM_DATA_W     = 32;
    localparam int MEM_BYTE_LANES = MEM_DATA_W / 8;

    typedef struct packed {
        logic [MEM_DATA_W-1:0]     addr;
        logic                      wen;
        logic [MEM_BYTE_LANES-1:0] wstrb;
        logic [MEM_DATA_W-1:0]     wdata;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_W-1:0] data;
        logic                  err;
    } mem_rsp_t;
endpackage

// File: rtl/dl_fifo.sv
// dl_fifo: in-order buffer with registered storage; head entry is always visible on rdata.
module dl_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= wrap_inc(r_wr);
            if (pop) r_rd <= wrap_inc(r_rd);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr] <= wdata;
    end

    assign rdata = r_mem[r_rd];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's load/store port; byte-writable word array
// with in-order buffered responses so the core may stall.
module dmem_responder
    import core_types_pkg::*;
#(
    parameter int N_BITS      = MEM_DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [N_BITS-1:0]   req_addr,
    input  logic                req_wen,
    input  logic [N_BITS/8-1:0] req_wstrb,
    input  logic [N_BITS-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N_BITS-1:0]   rsp_data,
    output logic                rsp_err
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int OW = $clog2(RSP_DEPTH + 1);
    localparam int RW = $bits(mem_rsp_t);

    logic [N_BITS-1:0] r_mem [DEPTH_WORDS];
    logic [OW-1:0]     r_outstanding;
    mem_req_t          w_req;
    mem_rsp_t          w_rsp_push, w_rsp_head;
    logic [IW-1:0]     w_idx;
    logic [OW-1:0]     w_count;
    logic              w_err, w_accept, w_pop, w_full, w_empty;

    assign w_req      = '{addr: req_addr, wen: req_wen, wstrb: req_wstrb, wdata: req_wdata};
    assign w_idx      = w_req.addr[2 +: IW];
    assign w_err      = (w_req.addr[1:0] != 2'b00) | (|w_req.addr[N_BITS-1:IW+2]);
    assign w_pop      = rsp_valid & rsp_ready;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign req_ready  = (r_outstanding < OW'(RSP_DEPTH)) | w_pop;
    assign w_accept   = req_valid & req_ready;
    assign w_rsp_push = '{data: (w_err | w_req.wen) ? '0 : r_mem[w_idx], err: w_err};

    always_ff @(posedge clk) begin
        if (w_accept & w_req.wen & ~w_err)
            for (int b = 0; b < MEM_BYTE_LANES; b++)
                if (w_req.wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_req.wdata[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_outstanding <= '0;
        else        r_outstanding <= r_outstanding + OW'(w_accept) - OW'(w_pop);
    end

    dl_fifo #(.WIDTH(RW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_accept),
        .pop   (w_pop),
        .wdata (w_rsp_push),
        .rdata (w_rsp_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign rsp_valid = ~w_empty;
    assign rsp_data  = rsp_valid ? w_rsp_head.data : '0;
    assign rsp_err   = rsp_valid & w_rsp_head.err;

    assert property (@(posedge clk) disable iff (!rst_n) r_outstanding == w_count);
    assert property (@(posedge clk) disable iff (!rst_n) !(w_accept && w_full && !w_pop));
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scenarios plus a randomized run scored against a word-array model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_data;
    logic [3:0]  req_wstrb;
    int          passed = 0, total = 0;
    logic [31:0] model [1024];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_responder #(.N_BITS(32), .DEPTH_WORDS(1024), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wen(req_wen), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        req_valid = v; req_addr = a; req_wen = w; req_wstrb = s; req_wdata = d;
    endtask

    task automatic idle_cycles(input int n);
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (n) tick();
    endtask

    task automatic put(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] d);
        drive(1'b1, a, w, s, d);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rsp_err); else passed++;
        total++; if (rsp_data !== 32'h0) $display("FAIL reset_data: got %h want 0", rsp_data); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
    endtask

    task automatic test_store_load();
        drive(1'b1, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL sl_ready: got %b want 1", req_ready); else passed++;
        tick();
        drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL sl_store_valid: got %b want 1", rsp_valid); else passed++;
        total++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) $display("FAIL sl_store_rsp: got %h/%b want 0/0", rsp_data, rsp_err); else passed++;
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL sl_load_valid: got %b want 1", rsp_valid); else passed++;
        total++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL sl_load_data: got %h want deadbeef", rsp_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL sl_drained: got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_partial_store();
        drive(1'b1, 32'h10, 1'b1, 4'b0001, 32'h000000AA);
        tick();
        drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEAA) $display("FAIL partial_data: got %b/%h want 1/deadbeaa", rsp_valid, rsp_data); else passed++;
        idle_cycles(2);
    endtask

    task automatic test_backpressure();
        put(32'h14, 1'b1, 4'hF, 32'hCAFEF00D);
        idle_cycles(2);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", req_ready); else passed++;
        tick();
        drive(1'b1, 32'h14, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL bp_ready2: got %b want 1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEAA) $display("FAIL bp_head: got %b/%h want 1/deadbeaa", rsp_valid, rsp_data); else passed++;
        tick();
        drive(1'b1, 32'h10, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", req_ready); else passed++;
        tick();
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL bp_still_full: got %b want 0", req_ready); else passed++;
        total++; if (rsp_data !== 32'hDEADBEAA || rsp_valid !== 1'b1) $display("FAIL bp_stable: got %b/%h want 1/deadbeaa", rsp_valid, rsp_data); else passed++;
        rsp_ready = 1'b1;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL bp_pop_ready: got %b want 1", req_ready); else passed++;
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_data !== 32'hCAFEF00D) $display("FAIL bp_second: got %h want cafef00d", rsp_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEADBEAA) $display("FAIL bp_third: got %b/%h want 1/deadbeaa", rsp_valid, rsp_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL bp_empty: got %b want 0", rsp_valid); else passed++;
    endtask

    task automatic test_errors();
        put(32'h0, 1'b1, 4'hF, 32'h12345678);
        idle_cycles(2);
        drive(1'b1, 32'h13, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) $display("FAIL err_misaligned: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_data); else passed++;
        tick();
        drive(1'b1, 32'h1000, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) $display("FAIL err_range_load: got %b/%b/%h want 1/1/0", rsp_valid, rsp_err, rsp_data); else passed++;
        tick();
        drive(1'b1, 32'h1000, 1'b1, 4'hF, 32'hFFFFFFFF);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_err !== 1'b1 || rsp_data !== 32'h0) $display("FAIL err_range_store: got %b/%h want 1/0", rsp_err, rsp_data); else passed++;
        tick();
        drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_data !== 32'h12345678 || rsp_err !== 1'b0) $display("FAIL err_word0_intact: got %h/%b want 12345678/0", rsp_data, rsp_err); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        put(32'h20, 1'b1, 4'hF, 32'h0BADF00D);
        idle_cycles(2);
        rsp_ready = 1'b0;
        drive(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b1, 32'h24, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL rm_buffered: got %b want 1", rsp_valid); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rm_async_drop: got %b want 0", rsp_valid); else passed++;
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL rm_no_stale1: got %b want 0", rsp_valid); else passed++;
        tick();
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rm_no_stale2: got valid %b ready %b want 0/1", rsp_valid, req_ready); else passed++;
        drive(1'b1, 32'h20, 1'b0, 4'h0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0BADF00D) $display("FAIL rm_persist: got %b/%h want 1/0badf00d", rsp_valid, rsp_data); else passed++;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic        acc;
        int          k, idx;
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model[i] = d;
            put(32'(4 * i), 1'b1, 4'hF, d);
        end
        idle_cycles(2);
        acc = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (acc) begin
                k = $urandom_range(0, 9);
                a = (k == 0) ? 32'(32'h1000 + 4 * $urandom_range(0, 255)) :
                    (k == 1) ? 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3)) :
                               32'(4 * $urandom_range(0, 15));
                drive($urandom_range(0, 9) < 7, a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
            end
            rsp_ready = $urandom_range(0, 9) < 6;
            @(negedge clk);
            total++; if (rsp_valid !== (exp_q.size() != 0)) $display("FAIL rnd_valid: cycle %0d got %b want %b", n, rsp_valid, exp_q.size() != 0); else passed++;
            total++; if (req_ready !== ((exp_q.size() < 2) || (exp_q.size() != 0 && rsp_ready))) $display("FAIL rnd_ready: cycle %0d got %b with %0d queued", n, req_ready, exp_q.size()); else passed++;
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
                total++; if ({rsp_data, rsp_err} !== exp_q[0]) $display("FAIL rnd_rsp: cycle %0d got %h/%b want %h/%b", n, rsp_data, rsp_err, exp_q[0][32:1], exp_q[0][0]); else passed++;
                void'(exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                idx = int'(req_addr / 4);
                if (req_addr % 4 != 0 || req_addr >= 4 * 1024) exp_q.push_back({32'h0, 1'b1});
                else if (req_wen) begin
                    exp_q.push_back({32'h0, 1'b0});
                    for (int b = 0; b < 4; b++)
                        if (req_wstrb[b]) model[idx][8*b +: 8] = req_wdata[8*b +: 8];
                end else exp_q.push_back({model[idx], 1'b0});
            end
            acc = !req_valid || req_ready;
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (rsp_valid && exp_q.size() != 0) begin
                total++; if ({rsp_data, rsp_err} !== exp_q[0]) $display("FAIL rnd_drain: got %h/%b want %h/%b", rsp_data, rsp_err, exp_q[0][32:1], exp_q[0][0]); else passed++;
                void'(exp_q.pop_front());
            end
            tick();
        end
        @(negedge clk);
        total++; if (exp_q.size() != 0 || rsp_valid !== 1'b0) $display("FAIL rnd_drain_empty: %0d missing, valid %b, want 0/0", exp_q.size(), rsp_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
